// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: credit-limited word fetches into a small in-order queue,
// with redirect flushing the queue and squashing responses still in flight.
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    i_clock,
    input  logic                    i_reset,        // active-low, asynchronous
    input  logic                    i_redirect,
    input  logic [31:0]             i_redirect_pc,
    output logic                    o_imem_req,
    output logic [31:0]             o_imem_addr,
    input  logic                    i_imem_gnt,
    input  logic                    i_imem_rvalid,
    input  logic [31:0]             i_imem_rdata,
    output logic                    o_inst_valid,
    input  logic                    i_inst_ready,
    output logic [31:0]             o_inst,
    output logic [31:0]             o_inst_pc,
    output logic [31:0]             o_inst_pc4,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Repeated redirects can pile up squashed fetches beyond DEPTH while new ones issue.
    localparam int SW = AW + 5;
    localparam int ND = int'(DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t         r_state;
    logic [31:0]    r_fetch_pc;
    logic [CW-1:0]  r_live;
    logic [SW-1:0]  r_stale;

    logic [31:0]    r_tag [DEPTH];
    logic [AW-1:0]  r_tag_wr;
    logic [AW-1:0]  r_tag_rd;

    logic [31:0]    r_dat [DEPTH];
    logic [31:0]    r_dpc [DEPTH];
    logic [AW-1:0]  r_wr;
    logic [AW-1:0]  r_rd;
    logic [CW-1:0]  r_count;

    logic [CW:0]    w_inflight;
    logic           w_room;
    logic           w_issue;
    logic           w_draining;
    logic           w_rsp_stale;
    logic           w_rsp_live;
    logic           w_rsp_any;
    logic           w_push;
    logic           w_pop;
    logic [SW-1:0]  w_stale_redir;

    // Credit counts both queued words and live fetches, so a push can never overflow.
    assign w_inflight  = {1'b0, r_live} + {1'b0, r_count};
    assign w_room      = (w_inflight < DEPTH_W);
    assign o_imem_req  = i_reset & ~i_redirect & w_room;
    assign o_imem_addr = r_fetch_pc;
    assign w_issue     = o_imem_req & i_imem_gnt;

    assign w_draining  = (r_state == ST_DRAIN);
    assign w_rsp_stale = i_imem_rvalid & ~i_redirect & w_draining;
    assign w_rsp_live  = i_imem_rvalid & ~i_redirect & ~w_draining & (r_live != '0);
    assign w_push      = w_rsp_live;
    assign w_pop       = o_inst_valid & i_inst_ready & ~i_redirect;

    // A response landing in the redirect cycle retires one outstanding fetch, whichever kind.
    assign w_rsp_any     = i_imem_rvalid & ((r_stale != '0) | (r_live != '0));
    assign w_stale_redir = r_stale + SW'(r_live) - SW'(w_rsp_any);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_FETCH;
            r_fetch_pc <= RESET_PC;
            r_live     <= '0;
            r_stale    <= '0;
        end else if (i_redirect) begin
            r_fetch_pc <= {i_redirect_pc[31:2], 2'b00};
            r_live     <= '0;
            r_stale    <= w_stale_redir;
            r_state    <= (w_stale_redir != '0) ? ST_DRAIN : ST_FETCH;
        end else begin
            if (w_issue)
                r_fetch_pc <= r_fetch_pc + 32'd4;
            r_live  <= r_live + CW'(w_issue) - CW'(w_rsp_live);
            r_stale <= r_stale - SW'(w_rsp_stale);
            if (r_state == ST_DRAIN) begin
                if (w_rsp_stale && (r_stale == SW'(1)))
                    r_state <= ST_FETCH;
            end else begin
                r_state <= ST_FETCH;
            end
        end
    end

    // PC of every live fetch, in issue order; the head tags the next non-squashed response.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_tag_wr <= '0;
            r_tag_rd <= '0;
            for (int i = 0; i < ND; i++)
                r_tag[i] <= '0;
        end else if (i_redirect) begin
            r_tag_wr <= '0;
            r_tag_rd <= '0;
        end else begin
            if (w_issue) begin
                r_tag[r_tag_wr] <= r_fetch_pc;
                r_tag_wr        <= r_tag_wr + AW'(1);
            end
            if (w_rsp_live)
                r_tag_rd <= r_tag_rd + AW'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < ND; i++) begin
                r_dat[i] <= '0;
                r_dpc[i] <= '0;
            end
        end else if (i_redirect) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_dat[r_wr] <= i_imem_rdata;
                r_dpc[r_wr] <= r_tag[r_tag_rd];
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign o_inst_valid = (r_count != '0);
    assign o_inst       = r_dat[r_rd];
    assign o_inst_pc    = r_dpc[r_rd];
    assign o_inst_pc4   = i_reset ? (o_inst_pc + 32'd4) : 32'd0;
    assign o_count      = r_count;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: in-order imem model with programmable latency,
// hand-computed expectations at fixed cycles after each reset.
module tb_ifetch_queue;
    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        inst_valid;
    logic        ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic [2:0]  count;

    int n_cmp;
    int n_err;
    int lat;
    int n_issue;
    int mcyc;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .i_clock(clk), .i_reset(rst_n),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_imem_req(req), .o_imem_addr(addr), .i_imem_gnt(gnt),
        .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
        .o_inst_valid(inst_valid), .i_inst_ready(ready),
        .o_inst(inst), .o_inst_pc(inst_pc), .o_inst_pc4(inst_pc4),
        .o_count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hC0DE_F00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Leaves the caller at the start of the first cycle after reset release.
    task automatic do_reset();
        cyc();
        rst_n    = 1'b0;
        redirect = 1'b0;
        ready    = 1'b0;
        gnt      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // In-order instruction memory: a grant in cycle c answers in cycle c+lat.
    initial begin
        rvalid  = 1'b0;
        rdata   = '0;
        n_issue = 0;
        mcyc    = 0;
        forever begin
            @(posedge clk);
            #1;
            mcyc++;
            if (!rst_n) begin
                pend_addr.delete();
                pend_due.delete();
                n_issue = 0;
                rvalid  = 1'b0;
            end else if (pend_due.size() > 0 && pend_due[0] <= mcyc) begin
                rvalid = 1'b1;
                rdata  = word_at(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                rvalid = 1'b0;
            end
            @(negedge clk);
            if (rst_n && rvalid)
                chk("proto_rsp_expected", 32'((dut.r_live != 0) || (dut.r_stale != 0)), 32'd1);
            if (rst_n && req && gnt) begin
                pend_addr.push_back(addr);
                pend_due.push_back(mcyc + lat);
                n_issue++;
            end
        end
    end

    initial begin
        n_cmp = 0; n_err = 0; lat = 1;
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; gnt = 1'b0; ready = 1'b0;

        // 1: reset state (redirect held during reset must be ignored), then streaming
        cyc();
        redirect = 1'b1; redirect_pc = 32'h0000_0500; gnt = 1'b1; ready = 1'b1;
        mid();
        chk("rst_req", 32'(req), 0);
        chk("rst_valid", 32'(inst_valid), 0);
        chk("rst_inst", inst, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_pc4", inst_pc4, 0);
        chk("rst_count", 32'(count), 0);
        cyc();
        redirect = 1'b0; rst_n = 1'b1;
        mid();
        chk("t1_addr0", addr, 32'h0);
        chk("t1_req0", 32'(req), 1);
        chk("t1_valid0", 32'(inst_valid), 0);
        cyc(); mid();
        chk("t1_addr1", addr, 32'h4);
        chk("t1_valid1", 32'(inst_valid), 0);
        cyc(); mid();
        chk("t1_valid2", 32'(inst_valid), 1);
        chk("t1_pc2", inst_pc, 32'h0);
        chk("t1_pc4_2", inst_pc4, 32'h4);
        chk("t1_inst2", inst, word_at(32'h0));
        chk("t1_addr2", addr, 32'h8);
        for (int k = 3; k < 8; k++) begin
            cyc(); mid();
            chk("t1_pc", inst_pc, 32'(4 * (k - 2)));
            chk("t1_inst", inst, word_at(32'(4 * (k - 2))));
            chk("t1_addr", addr, 32'(4 * k));
            chk("t1_count", 32'(count), 1);
        end

        // 2: back-pressure fills the queue after exactly DEPTH grants
        do_reset();
        lat = 1; gnt = 1'b1; ready = 1'b0;
        mid();
        cyc(); mid();
        cyc(); mid();
        cyc(); mid();
        chk("t2_addr3", addr, 32'hC);
        chk("t2_req3", 32'(req), 1);
        cyc(); mid();
        chk("t2_req4", 32'(req), 0);
        cyc(); mid();
        chk("t2_req5", 32'(req), 0);
        chk("t2_count5", 32'(count), 4);
        chk("t2_issues5", 32'(n_issue), 4);
        chk("t2_pc5", inst_pc, 32'h0);
        chk("t2_inst5", inst, word_at(32'h0));
        cyc();
        ready = 1'b1;
        mid();
        chk("t2_valid6", 32'(inst_valid), 1);
        cyc();
        ready = 1'b0;
        mid();
        chk("t2_count7", 32'(count), 3);
        chk("t2_req7", 32'(req), 1);
        chk("t2_addr7", addr, 32'h10);
        chk("t2_pc7", inst_pc, 32'h4);
        cyc(); mid();
        chk("t2_issues8", 32'(n_issue), 5);
        chk("t2_req8", 32'(req), 0);

        // 3: latency 3, two in flight, redirect to an unaligned PC
        do_reset();
        lat = 3; gnt = 1'b1; ready = 1'b1;
        mid();
        chk("t3_addr0", addr, 32'h0);
        cyc(); mid();
        chk("t3_addr1", addr, 32'h4);
        cyc();
        gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0102;
        mid();
        chk("t3_req_redir", 32'(req), 0);
        cyc();
        redirect = 1'b0; gnt = 1'b1;
        mid();
        chk("t3_addr3", addr, 32'h100);
        chk("t3_req3", 32'(req), 1);
        chk("t3_state3", 32'(dut.r_state), 1);
        chk("t3_stale3", 32'(dut.r_stale), 2);
        chk("t3_count3", 32'(count), 0);
        cyc(); mid();
        chk("t3_addr4", addr, 32'h104);
        chk("t3_valid4", 32'(inst_valid), 0);
        chk("t3_stale4", 32'(dut.r_stale), 1);
        cyc(); mid();
        chk("t3_state5", 32'(dut.r_state), 0);
        chk("t3_valid5", 32'(inst_valid), 0);
        cyc(); mid();
        chk("t3_valid6", 32'(inst_valid), 0);
        cyc(); mid();
        chk("t3_valid7", 32'(inst_valid), 1);
        chk("t3_pc7", inst_pc, 32'h100);
        chk("t3_inst7", inst, word_at(32'h100));
        chk("t3_pc4_7", inst_pc4, 32'h104);

        // 4: redirect in the same cycle as a response with the consumer ready
        do_reset();
        lat = 2; gnt = 1'b1; ready = 1'b1;
        mid();
        cyc(); mid();
        cyc(); mid();
        chk("t4_valid2", 32'(inst_valid), 0);
        cyc();
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        mid();
        chk("t4_req_redir", 32'(req), 0);
        chk("t4_valid_redir", 32'(inst_valid), 1);
        chk("t4_live_redir", 32'(dut.r_live), 2);
        cyc();
        redirect = 1'b0;
        mid();
        chk("t4_count4", 32'(count), 0);
        chk("t4_valid4", 32'(inst_valid), 0);
        chk("t4_stale4", 32'(dut.r_stale), 1);
        chk("t4_state4", 32'(dut.r_state), 1);
        chk("t4_addr4", addr, 32'h200);
        cyc(); mid();
        chk("t4_stale5", 32'(dut.r_stale), 0);
        chk("t4_state5", 32'(dut.r_state), 0);
        chk("t4_count5", 32'(count), 0);
        cyc(); mid();
        chk("t4_valid6", 32'(inst_valid), 0);
        cyc(); mid();
        chk("t4_pc7", inst_pc, 32'h200);
        chk("t4_inst7", inst, word_at(32'h200));

        // 5: back-to-back redirects with three fetches in flight
        do_reset();
        lat = 3; gnt = 1'b1; ready = 1'b1;
        mid();
        cyc(); mid();
        cyc(); mid();
        chk("t5_addr2", addr, 32'h8);
        cyc();
        redirect = 1'b1; redirect_pc = 32'h0000_0300;
        mid();
        chk("t5_req3", 32'(req), 0);
        chk("t5_valid3", 32'(inst_valid), 0);
        cyc();
        redirect_pc = 32'h0000_0400;
        mid();
        chk("t5_req4", 32'(req), 0);
        chk("t5_stale4", 32'(dut.r_stale), 2);
        chk("t5_state4", 32'(dut.r_state), 1);
        cyc();
        redirect = 1'b0;
        mid();
        chk("t5_addr5", addr, 32'h400);
        chk("t5_req5", 32'(req), 1);
        chk("t5_stale5", 32'(dut.r_stale), 1);
        for (int k = 6; k < 9; k++) begin
            cyc(); mid();
            chk("t5_valid_drain", 32'(inst_valid), 0);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(); mid();
            chk("t5_pc", inst_pc, 32'h400 + 32'(4 * k));
            chk("t5_inst", inst, word_at(32'h400 + 32'(4 * k)));
        end

        // 6: PC wrap at the top of the address space
        do_reset();
        lat = 1; gnt = 1'b1; ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        mid();
        chk("t6_req_redir", 32'(req), 0);
        cyc();
        redirect = 1'b0;
        mid();
        chk("t6_addr1", addr, 32'hFFFF_FFFC);
        chk("t6_state1", 32'(dut.r_state), 0);
        cyc(); mid();
        chk("t6_addr2", addr, 32'h0);
        cyc(); mid();
        chk("t6_pc3", inst_pc, 32'hFFFF_FFFC);
        chk("t6_pc4_3", inst_pc4, 32'h0);
        chk("t6_inst3", inst, word_at(32'hFFFF_FFFC));
        cyc(); mid();
        chk("t6_pc4", inst_pc, 32'h0);
        chk("t6_pc4_4", inst_pc4, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
